// File: rtl/vending_param.sv
// -----------------------------------------------------------------------------
// vending_param
//   Parametrised vending controller. It accepts nickel, dime and quarter pulses
//   and accumulates credit. It vends on BUY, then pays change one coin per cycle
//   using greedy Q/D/N selection. It also supports CANCEL (full refund), coin
//   rejection and an over-credit limit.
//
//   Optional feature macro: AUTO_VEND_EN
//     defined   : ACCUM enters VEND on the edge after credit reaches PRICE,
//                 BUY is ignored, CANCEL is honoured only while credit < PRICE.
//     undefined : VEND is entered only through BUY.
//
// Ports
//   Clk     in   clock, all logic on posedge
//   RST     in   synchronous active-high reset
//   N/D/Q   in   coin inserted (1-cycle pulses)
//   BUY     in   purchase request (1-cycle pulse)
//   CANCEL  in   refund request (1-cycle pulse)
//   CAN     out  dispense product (high for the single VEND cycle)
//   CHG_N/D/Q out pay out one coin of that kind this cycle
//   CREDIT  out  registered credit
//   REJ     out  coin presented this cycle is returned uncounted (combinational)
//   BUSY    out  high while in VEND or CHANGE
// -----------------------------------------------------------------------------
module vending_param #(
    parameter int PRICE      = 30,
    parameter int VAL_N      = 5,
    parameter int VAL_D      = 10,
    parameter int VAL_Q      = 25,
    parameter int CREDIT_W   = 7,
    parameter int MAX_CREDIT = 95
) (
    input  logic                Clk,
    input  logic                RST,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                BUY,
    input  logic                CANCEL,
    output logic                CAN,
    output logic                CHG_N,
    output logic                CHG_D,
    output logic                CHG_Q,
    output logic [CREDIT_W-1:0] CREDIT,
    output logic                REJ,
    output logic                BUSY
);

    localparam logic [CREDIT_W-1:0] W_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] W_VAL_N = CREDIT_W'(VAL_N);
    localparam logic [CREDIT_W-1:0] W_VAL_D = CREDIT_W'(VAL_D);
    localparam logic [CREDIT_W-1:0] W_VAL_Q = CREDIT_W'(VAL_Q);
    localparam logic [CREDIT_W:0]   W_MAX   = (CREDIT_W+1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_next;

    // ------------------------------------------------------------------
    // Coin decode
    // ------------------------------------------------------------------
    logic [2:0]          w_coin;
    logic                w_coin_any;
    logic                w_coin_valid;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W:0]   w_sum;
    logic                w_fits;
    logic                w_accept;

    assign w_coin     = {Q, D, N};
    assign w_coin_any = |w_coin;
    // One-hot test: a nonzero vector with a single bit set.
    assign w_coin_valid = w_coin_any && ((w_coin & (w_coin - 3'd1)) == 3'd0);
    assign w_coin_val   = Q ? W_VAL_Q : (D ? W_VAL_D : W_VAL_N);
    // One extra bit so that the limit compare cannot wrap.
    assign w_sum  = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_fits = (w_sum <= W_MAX);

    // ------------------------------------------------------------------
    // Change coin selection (Moore, from registered credit)
    // ------------------------------------------------------------------
    logic                w_sel_q;
    logic                w_sel_d;
    logic [CREDIT_W-1:0] w_chg_val;
    logic [CREDIT_W-1:0] w_after_price;
    logic [CREDIT_W-1:0] w_after_chg;

    assign w_sel_q       = (r_credit >= W_VAL_Q);
    assign w_sel_d       = !w_sel_q && (r_credit >= W_VAL_D);
    assign w_chg_val     = w_sel_q ? W_VAL_Q : (w_sel_d ? W_VAL_D : W_VAL_N);
    assign w_after_price = r_credit - W_PRICE;
    assign w_after_chg   = r_credit - w_chg_val;

    // ------------------------------------------------------------------
    // Decisions taken in ACCUM (CANCEL > BUY > coin in manual mode)
    // ------------------------------------------------------------------
    logic w_go_vend;
    logic w_go_cancel;
    logic w_price_met;

    assign w_price_met = (r_credit >= W_PRICE);

`ifdef AUTO_VEND_EN
    // Reaching the price wins over everything; CANCEL only matters below it.
    logic w_unused_buy;
    assign w_unused_buy = BUY;
    assign w_go_vend    = (r_state == S_ACCUM) && w_price_met;
    assign w_go_cancel  = (r_state == S_ACCUM) && !w_price_met && CANCEL;
`else
    assign w_go_cancel  = (r_state == S_ACCUM) && CANCEL;
    assign w_go_vend    = (r_state == S_ACCUM) && !CANCEL && BUY && w_price_met;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
        end else begin
            r_state  <= w_state_next;
            r_credit <= w_credit_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_credit_next = r_credit;
        w_accept      = 1'b0;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_go_cancel) begin
                    w_state_next = S_CHANGE;
                end else if (w_go_vend) begin
                    w_state_next = S_VEND;
                end else if (w_coin_valid && w_fits) begin
                    w_accept      = 1'b1;
                    w_credit_next = w_sum[CREDIT_W-1:0];
                    w_state_next  = S_ACCUM;
                end
            end
            S_VEND: begin
                w_credit_next = w_after_price;
                w_state_next  = (w_after_price != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                w_credit_next = w_after_chg;
                w_state_next  = (w_after_chg != '0) ? S_CHANGE : S_IDLE;
            end
            default: begin
                w_state_next  = S_IDLE;
                w_credit_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Everything except REJ comes from registered state
    // and credit, so these outputs are glitch-free.
    // ------------------------------------------------------------------
    always_comb begin
        CAN   = 1'b0;
        CHG_Q = 1'b0;
        CHG_D = 1'b0;
        CHG_N = 1'b0;
        BUSY  = 1'b0;
        case (r_state)
            S_VEND: begin
                CAN  = 1'b1;
                BUSY = 1'b1;
            end
            S_CHANGE: begin
                CHG_Q = w_sel_q;
                CHG_D = w_sel_d;
                CHG_N = !w_sel_q && !w_sel_d;
                BUSY  = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    assign REJ    = w_coin_any && !w_accept;
    assign CREDIT = r_credit;

endmodule
